obstacle_manager: RTL and testbench
===================================

Name: obstacle_manager

Overview:
Owns the per-lane obstacle table consumed directly by track_draw, replacing ad-hoc per-frame position decrements at the top level. Once per video frame it advances every active obstacle toward the player, retires passed obstacles, detects player collisions, and spawns new obstacles from an LFSR. It runs on the 65 MHz video clock and sits between the game FSM/vision result (lane, jump) and track_draw.

Parameters:
NUM_SLOTS, 10, number of obstacle table entries
SPAWN_POS, 11'd1023, position written into a newly spawned obstacle
HIT_LO, 11'd0, lowest position of the player collision window (inclusive)
HIT_HI, 11'd47, highest position of the player collision window (inclusive)
SPAWN_GAP, 8'd30, minimum number of frames between spawns
LFSR_SEED, 16'hACE1, LFSR value after reset; must be nonzero

Ports:
system_clock_in  input  1  65 MHz video clock
reset_n_in  input  1  asynchronous, active-low reset
frame_tick_in  input  1  one-cycle pulse per frame, issued in vertical blank
run_in  input  1  1 = game running; 0 = ignore ticks and freeze table
clear_in  input  1  synchronous clear of the table and the counters
speed_in  input  3  pixels advanced per frame, 0..7
player_lane_in  input  2  player lane, 0..2
player_jump_in  input  1  player is airborne
obstacles_out  output  NUM_SLOTS*16  packed obstacle_t array; slot i occupies [16i+15:16i]
collision_out  output  1  one-cycle pulse when a collision is detected
passed_count_out  output  16  obstacles passed without a hit; saturates at 16'hFFFF
busy_out  output  1  high while a frame update is in progress

Behaviour:
- obstacle_t is 16 bits: type[15:14], position[13:3] (11 bits), lane[2:1], active[0].
- Async reset (reset_n_in=0): all slots 0, collision_out 0, passed_count_out 0, busy_out 0, state IDLE, frame counter 0, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps every clock outside reset and is not affected by clear_in.
- FSM: IDLE -> UPDATE (idx 0..NUM_SLOTS-1, one slot per cycle) -> SPAWN -> IDLE.
- IDLE: when frame_tick_in && run_in && !clear_in, go to UPDATE with idx=0, set busy_out=1, and increment the frame counter (saturates at 255). A tick received in any other state is dropped.
- UPDATE, slot idx: if the slot is inactive, leave it unchanged. Otherwise:
  - If position < speed_in: clear active and increment passed_count_out (saturating).
  - Else: newpos = position - speed_in.
  - If newpos is in [HIT_LO,HIT_HI], lane == player_lane_in, and !(type==0 && player_jump_in): this is a hit. Clear active and set the per-frame hit flag. type 0 is jumpable; types 1-3 are not.
  - Otherwise write newpos.
- SPAWN: spawn when frame counter >= SPAWN_GAP and LFSR[0]=1.
  - Target: the lowest-index inactive slot. Write type={1'b0,LFSR[3]}, position=SPAWN_POS, lane=LFSR[2:1] (3 maps to 1), active=1. Reset the frame counter to 0.
  - If no slot is free, skip the spawn and hold the frame counter.
- collision_out pulses for one cycle in the SPAWN cycle if the hit flag is set. There is at most one pulse per frame, and the hit flag is then cleared.
- Latency: tick at cycle T; slots update at T+1..T+NUM_SLOTS; SPAWN at T+NUM_SLOTS+1; busy_out drops and the table is final at T+NUM_SLOTS+2 (12 cycles at default). This is well inside vertical blank.
- clear_in has the highest priority on any cycle:
  - Zeroes all slots, passed_count_out, frame counter and hit flag.
  - Aborts UPDATE/SPAWN, returns to IDLE, and drops busy_out next cycle.
  - A tick coincident with clear_in is dropped.
- run_in=0 mid-update: the update completes; only new ticks are gated.
- speed_in=0: positions are unchanged, but collision checks still apply.
- Inputs are sampled in the cycle each slot is processed. Callers hold them stable in blank.

Decomposition:
- Shared package (data.sv): obstacle_t struct, NUM_OBSTACLES=10, OBS_TYPE_LOW=2'd0, OBS_TYPE_TALL=2'd1, LANE_COUNT=3.
- Sub-module lfsr16 (parameter SEED; ports system_clock_in, reset_n_in, value_out[15:0]) is natural and reused later for scoring/effects.

Test Plan:
- Reset then a tick with an empty table, SPAWN_GAP=0, and LFSR[0]=1 on the SPAWN cycle -> slot 0 = {type, 1023, lane<=2, 1}, busy_out high for 11 cycles.
- Slot 3 = {0, 20, 1, 1}, speed_in=5, lane_in=2 -> over 4 ticks position goes 15,10,5,0; the 5th tick retires it, passed_count_out=1, no collision.
- Slot 0 = {1, 50, 0, 1}, speed_in=3, lane_in=0, jump=1 -> newpos 47, slot cleared, one collision_out pulse at T+11, passed_count_out unchanged.
- Same as the previous case with type=0 and jump=1 -> no collision, position 47. With jump=0 -> collision pulse.
- All 10 slots active at 900, spawn due -> no slot is overwritten and the frame counter is held; retire slot 4 -> the next spawn lands in slot 4.
- clear_in asserted at T+5 of an update with frame_tick_in also high -> all slots 0, passed_count_out 0, busy_out low at T+6, no collision pulse.

Source files
------------

// File: rtl/obstacle_manager_pkg.sv
// Shared types and constants for the per-lane obstacle table.
// obstacle_t is the 16-bit slot format consumed directly by track_draw.
package obstacle_manager_pkg;

  localparam int         NUM_OBSTACLES = 10;
  localparam logic [1:0] OBS_TYPE_LOW  = 2'd0;
  localparam logic [1:0] OBS_TYPE_TALL = 2'd1;
  localparam logic [1:0] LANE_COUNT    = 2'd3;

  typedef struct packed {
    logic [1:0]  obs_type;
    logic [10:0] position;
    logic [1:0]  lane;
    logic        active;
  } obstacle_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } state_t;

  // Two random bits give four codes for three lanes; the spare code folds onto lane 1.
  function automatic logic [1:0] lane_from_bits(input logic [1:0] bits);
    return (bits >= LANE_COUNT) ? 2'd1 : bits;
  endfunction

endpackage

// File: rtl/obstacle_manager_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting right every clock.
// Free-running so its value is also usable by scoring and effects logic.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        system_clock_in,
  input  logic        reset_n_in,
  output logic [15:0] value_out
);

  logic [15:0] lfsr_reg;
  logic        feedback;

  assign feedback = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {feedback, lfsr_reg[15:1]};
    end
  end

  assign value_out = lfsr_reg;

endmodule

// File: rtl/obstacle_manager.sv
// Per-frame obstacle table owner: advances, retires and collides one slot per
// cycle after each frame tick, then optionally spawns a new obstacle.
module obstacle_manager
  import obstacle_manager_pkg::*;
#(
  parameter int          NUM_SLOTS = NUM_OBSTACLES,
  parameter logic [10:0] SPAWN_POS = 11'd1023,
  parameter logic [10:0] HIT_LO    = 11'd0,
  parameter logic [10:0] HIT_HI    = 11'd47,
  parameter logic [7:0]  SPAWN_GAP = 8'd30,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     system_clock_in,
  input  logic                     reset_n_in,
  input  logic                     frame_tick_in,
  input  logic                     run_in,
  input  logic                     clear_in,
  input  logic [2:0]               speed_in,
  input  logic [1:0]               player_lane_in,
  input  logic                     player_jump_in,
  output logic [NUM_SLOTS*16-1:0]  obstacles_out,
  output logic                     collision_out,
  output logic [15:0]              passed_count_out,
  output logic                     busy_out
);

  localparam int               IDX_W    = $clog2(NUM_SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  obstacle_t        slots_reg [NUM_SLOTS];
  logic [7:0]       frame_count_reg;
  logic [15:0]      passed_count_reg;
  logic             hit_flag_reg;

  logic [15:0]      lfsr_value;
  logic             unused_lfsr_bits;
  logic             start;
  obstacle_t        cur, updated, spawn_entry;
  logic [10:0]      newpos;
  logic             retire, in_window, hit;
  logic [NUM_SLOTS-1:0] free_mask;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             spawn_ok;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .system_clock_in (system_clock_in),
    .reset_n_in      (reset_n_in),
    .value_out       (lfsr_value)
  );

  // Upper LFSR bits are left for other consumers of the same generator.
  assign unused_lfsr_bits = ^lfsr_value[15:4];

  assign start = (state_reg == ST_IDLE) && frame_tick_in && run_in && !clear_in;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx_reg == IDX_W'(i)) cur = slots_reg[i];
    end
  end

  // Window test via offset subtraction: below HIT_LO wraps to a large value.
  always_comb begin
    newpos    = cur.position - {8'd0, speed_in};
    retire    = cur.active && (cur.position < {8'd0, speed_in});
    in_window = (newpos - HIT_LO) <= (HIT_HI - HIT_LO);
    hit       = cur.active && !retire && in_window && (cur.lane == player_lane_in)
                && !((cur.obs_type == OBS_TYPE_LOW) && player_jump_in);
    updated   = cur;
    if (retire || hit) begin
      updated.active = 1'b0;
    end else if (cur.active) begin
      updated.position = newpos;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign free_mask[gi]               = !slots_reg[gi].active;
      assign obstacles_out[16*gi +: 16]  = slots_reg[gi];
    end
  endgenerate

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    spawn_entry.obs_type = lfsr_value[3] ? OBS_TYPE_TALL : OBS_TYPE_LOW;
    spawn_entry.position = SPAWN_POS;
    spawn_entry.lane     = lane_from_bits(lfsr_value[2:1]);
    spawn_entry.active   = 1'b1;
    spawn_ok = (frame_count_reg >= SPAWN_GAP) && lfsr_value[0] && free_found;
  end

  // Slot table: clear dominates, then the per-slot update, then the spawn write.
  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_reg[i] <= '0;
    end else if (clear_in) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots_reg[i] <= '0;
    end else if (state_reg == ST_UPDATE) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (idx_reg == IDX_W'(i)) slots_reg[i] <= updated;
      end
    end else if ((state_reg == ST_SPAWN) && spawn_ok) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (free_idx == IDX_W'(i)) slots_reg[i] <= spawn_entry;
      end
    end
  end

  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      idx_reg          <= '0;
      frame_count_reg  <= '0;
      passed_count_reg <= '0;
      hit_flag_reg     <= 1'b0;
    end else if (clear_in) begin
      idx_reg          <= '0;
      frame_count_reg  <= '0;
      passed_count_reg <= '0;
      hit_flag_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          idx_reg <= '0;
          if (start && (frame_count_reg != 8'hFF)) frame_count_reg <= frame_count_reg + 8'd1;
        end
        ST_UPDATE: begin
          idx_reg <= idx_reg + 1'b1;
          if (retire && (passed_count_reg != 16'hFFFF)) passed_count_reg <= passed_count_reg + 16'd1;
          if (hit) hit_flag_reg <= 1'b1;
        end
        ST_SPAWN: begin
          hit_flag_reg <= 1'b0;
          if (spawn_ok) frame_count_reg <= '0;
        end
        default: idx_reg <= '0;
      endcase
    end
  end

  always_ff @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg <= ST_IDLE;
    end else if (clear_in) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_UPDATE;
      ST_UPDATE: if (idx_reg == LAST_IDX) state_next = ST_SPAWN;
      ST_SPAWN:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out      = (state_reg != ST_IDLE);
    collision_out = (state_reg == ST_SPAWN) && hit_flag_reg && !clear_in;
  end

  assign passed_count_out = passed_count_reg;

endmodule

// File: tb/tb_obstacle_manager.sv
// Directed bench for obstacle_manager: spawn content is steered by issuing each
// tick when a free-running LFSR reference shows the wanted bits on the spawn cycle.
module tb_obstacle_manager;

  logic         system_clock_in = 1'b0;
  logic         reset_n_in      = 1'b0;
  logic         frame_tick_in   = 1'b0;
  logic         run_in          = 1'b1;
  logic         clear_in        = 1'b0;
  logic [2:0]   speed_in        = 3'd0;
  logic [1:0]   player_lane_in  = 2'd0;
  logic         player_jump_in  = 1'b0;
  logic [159:0] obstacles_out;
  logic         collision_out;
  logic [15:0]  passed_count_out;
  logic         busy_out;

  int total = 0;
  int bad   = 0;
  int busy_cnt, coll_cnt, coll_at, coll_sum;
  logic busy_after;
  logic [15:0] lfsr_ref;
  logic [15:0] exp_tab [10];
  logic [15:0] exp_msk [10];

  obstacle_manager #(.SPAWN_GAP(8'd2)) dut (
    .system_clock_in  (system_clock_in),
    .reset_n_in       (reset_n_in),
    .frame_tick_in    (frame_tick_in),
    .run_in           (run_in),
    .clear_in         (clear_in),
    .speed_in         (speed_in),
    .player_lane_in   (player_lane_in),
    .player_jump_in   (player_jump_in),
    .obstacles_out    (obstacles_out),
    .collision_out    (collision_out),
    .passed_count_out (passed_count_out),
    .busy_out         (busy_out)
  );

  always #5 system_clock_in = ~system_clock_in;

  always @(posedge system_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) lfsr_ref <= 16'hACE1;
    else lfsr_ref <= {lfsr_ref[0] ^ lfsr_ref[2] ^ lfsr_ref[3] ^ lfsr_ref[5], lfsr_ref[15:1]};
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ahead(input logic [15:0] v, input int n);
    logic [15:0] x;
    x = v;
    for (int k = 0; k < n; k++) x = {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    return x;
  endfunction

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [10:0] p, input logic [1:0] l);
    return {t, p, l, 1'b1};
  endfunction

  function automatic logic [15:0] slot_at(input int i);
    return obstacles_out[16*i +: 16];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_slot%0d", tag, i), {16'd0, slot_at(i) & exp_msk[i]}, {16'd0, exp_tab[i] & exp_msk[i]});
  endtask

  task automatic set_cleared(input int i);
    exp_tab[i] = 16'h0000;
    exp_msk[i] = 16'h0001;
  endtask

  // Called at a negedge; waits until LFSR bits on the future spawn cycle match, then ticks.
  task automatic run_frame(input logic [3:0] mask, input logic [3:0] val);
    int waited;
    logic [15:0] fut;
    waited = 0;
    fut = ahead(lfsr_ref, 11);
    while (((fut[3:0] & mask) != val) && (waited < 1000)) begin
      @(negedge system_clock_in);
      waited++;
      fut = ahead(lfsr_ref, 11);
    end
    if (waited >= 1000) check("lfsr_wait_budget", waited, 0);
    frame_tick_in = 1'b1;
    @(negedge system_clock_in);
    frame_tick_in = 1'b0;
    busy_cnt = 0;
    coll_cnt = 0;
    coll_at  = -1;
    for (int c = 1; c <= 11; c++) begin
      if (busy_out) busy_cnt++;
      if (collision_out) begin
        coll_cnt++;
        coll_at = c;
      end
      @(negedge system_clock_in);
    end
    busy_after = busy_out;
    if (collision_out) coll_cnt++;
    $display("frame: speed=%0d lane=%0d jump=%0d busy=%0d coll=%0d passed=%0d",
             speed_in, player_lane_in, player_jump_in, busy_cnt, coll_cnt, passed_count_out);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      exp_tab[i] = 16'h0000;
      exp_msk[i] = 16'hFFFF;
    end
    repeat (3) @(negedge system_clock_in);
    check("rst_busy", busy_out, 0);
    check("rst_collision", collision_out, 0);
    check("rst_passed", passed_count_out, 0);
    check_table("rst");
    reset_n_in = 1'b1;
    @(negedge system_clock_in);

    // Frame counter 1 < gap: no spawn even with LFSR[0]=1
    run_frame(4'h1, 4'h1);
    check("gap_busy_cycles", busy_cnt, 11);
    check("gap_busy_after", busy_after, 0);
    check("gap_collision", coll_cnt, 0);
    check_table("gap");

    run_frame(4'hF, 4'h9);
    exp_tab[0] = mk(2'd1, 11'd1023, 2'd0);
    check("spawn0_busy_cycles", busy_cnt, 11);
    check("spawn0_busy_after", busy_after, 0);
    check_table("spawn0");
    run_frame(4'h0, 4'h0);
    run_frame(4'hF, 4'h1);
    exp_tab[1] = mk(2'd0, 11'd1023, 2'd0);
    run_frame(4'h0, 4'h0);
    run_frame(4'hF, 4'h5);
    exp_tab[2] = mk(2'd0, 11'd1023, 2'd2);
    check_table("spawn2");

    // 139 frames at speed 7: 1023 -> 50
    speed_in = 3'd7; player_lane_in = 2'd1; coll_sum = 0;
    repeat (139) begin run_frame(4'h1, 4'h0); coll_sum += coll_cnt; end
    check("approach_collisions", coll_sum, 0);
    exp_tab[0] = mk(2'd1, 11'd50, 2'd0);
    exp_tab[1] = mk(2'd0, 11'd50, 2'd0);
    exp_tab[2] = mk(2'd0, 11'd50, 2'd2);
    check_table("approach");

    // Tall obstacle hits a jumping player; low one is jumped at 47
    speed_in = 3'd3; player_lane_in = 2'd0; player_jump_in = 1'b1;
    run_frame(4'h1, 4'h0);
    set_cleared(0);
    exp_tab[1] = mk(2'd0, 11'd47, 2'd0);
    exp_tab[2] = mk(2'd0, 11'd47, 2'd2);
    check("tall_hit_pulses", coll_cnt, 1);
    check("tall_hit_cycle", coll_at, 11);
    check("tall_hit_passed", passed_count_out, 0);
    check_table("tall_hit");

    player_jump_in = 1'b0;
    run_frame(4'h1, 4'h0);
    set_cleared(1);
    exp_tab[2] = mk(2'd0, 11'd44, 2'd2);
    check("low_hit_pulses", coll_cnt, 1);
    check_table("low_hit");

    speed_in = 3'd5; coll_sum = 0;
    repeat (8) begin run_frame(4'h1, 4'h0); coll_sum += coll_cnt; end
    exp_tab[2] = mk(2'd0, 11'd4, 2'd2);
    check("other_lane_collisions", coll_sum, 0);
    check_table("near_end");
    run_frame(4'h1, 4'h0);
    set_cleared(2);
    check("retire_passed", passed_count_out, 1);
    check("retire_collision", coll_cnt, 0);
    check_table("retire");

    // Fill all ten slots; slot 4 alone in lane 0, lane code 3 folds to 1
    speed_in = 3'd0;
    for (int i = 0; i < 10; i++) begin
      run_frame(4'h1, 4'h0);
      if (i == 4) begin
        run_frame(4'hF, 4'h1);
        exp_tab[i] = mk(2'd0, 11'd1023, 2'd0);
      end else begin
        run_frame(4'hF, (i % 2 == 1) ? 4'h7 : 4'h3);
        exp_tab[i] = mk(2'd0, 11'd1023, 2'd1);
      end
      exp_msk[i] = 16'hFFFF;
    end
    check_table("fill");
    run_frame(4'h1, 4'h0);
    run_frame(4'h1, 4'h1);
    check_table("full_no_overwrite");

    speed_in = 3'd7;
    repeat (139) run_frame(4'h1, 4'h0);
    for (int i = 0; i < 10; i++) exp_tab[i] = mk(2'd0, 11'd50, (i == 4) ? 2'd0 : 2'd1);
    check_table("full_approach");

    speed_in = 3'd3;
    run_frame(4'h1, 4'h0);
    for (int i = 0; i < 10; i++) exp_tab[i] = mk(2'd0, 11'd47, 2'd1);
    set_cleared(4);
    check("slot4_hit_pulses", coll_cnt, 1);
    check_table("slot4_hit");

    speed_in = 3'd0;
    run_frame(4'hF, 4'h9);
    exp_tab[4] = mk(2'd1, 11'd1023, 2'd0);
    exp_msk[4] = 16'hFFFF;
    check_table("respawn4");

    // Clear at T+5 with a coincident tick; slot 0 has already hit at T+1
    player_lane_in = 2'd1;
    coll_sum = 0;
    frame_tick_in = 1'b1;
    @(negedge system_clock_in);
    frame_tick_in = 1'b0;
    repeat (4) begin
      if (collision_out) coll_sum++;
      @(negedge system_clock_in);
    end
    clear_in = 1'b1; frame_tick_in = 1'b1;
    @(negedge system_clock_in);
    clear_in = 1'b0; frame_tick_in = 1'b0;
    check("clear_busy_next", busy_out, 0);
    check("clear_passed", passed_count_out, 0);
    for (int i = 0; i < 10; i++) begin exp_tab[i] = 16'h0000; exp_msk[i] = 16'hFFFF; end
    check_table("clear");
    busy_cnt = 0;
    repeat (8) begin
      if (collision_out) coll_sum++;
      if (busy_out) busy_cnt++;
      @(negedge system_clock_in);
    end
    check("clear_no_collision", coll_sum, 0);
    check("clear_tick_dropped", busy_cnt, 0);
    $display("clear: busy_after=%0d collisions=%0d", busy_cnt, coll_sum);

    // Frame counter was cleared: first frame after clear cannot spawn
    player_lane_in = 2'd0;
    run_frame(4'h1, 4'h1);
    check("post_clear_busy", busy_cnt, 11);
    check_table("post_clear_gap");

    run_in = 1'b0;
    frame_tick_in = 1'b1;
    @(negedge system_clock_in);
    frame_tick_in = 1'b0;
    busy_cnt = 0;
    repeat (3) begin if (busy_out) busy_cnt++; @(negedge system_clock_in); end
    check("run_low_tick_ignored", busy_cnt, 0);
    run_in = 1'b1;
    clear_in = 1'b1; frame_tick_in = 1'b1;
    @(negedge system_clock_in);
    clear_in = 1'b0; frame_tick_in = 1'b0;
    busy_cnt = 0;
    repeat (3) begin if (busy_out) busy_cnt++; @(negedge system_clock_in); end
    check("clear_tick_idle_dropped", busy_cnt, 0);
    $display("gating: run_low and clear ticks checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
